// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: fetch FSM states and fetch constants.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES       = 32'd4;

   typedef enum logic {
      REQ  = 1'b0,
      FULL = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over a req/ready handshake and presents
// one instruction at a time to IF/ID, with stall, redirect/flush and an IF/ID mirror.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IFIDWrite,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic [31:0] ImemRdata,
   output logic [31:0] PCAddResult,
   output logic [31:0] Instruction,
   output logic        FetchValid,
   output logic [31:0] pcback,
   output logic [31:0] instructionback
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  buf_pc4_reg, buf_pc4_next;
   logic [31:0]  buf_inst_reg, buf_inst_next;
   logic [31:0]  pcback_reg, pcback_next;
   logic [31:0]  instback_reg, instback_next;
   logic [31:0]  pc_plus4;

   // The buffer may hold a stale word after FULL->REQ, so presentation is gated by state.
   assign FetchValid      = (state_reg == FULL);
   assign PCAddResult     = FetchValid ? buf_pc4_reg  : 32'h0;
   assign Instruction     = FetchValid ? buf_inst_reg : NOP_INSTR;
   assign ImemAddr        = Reset ? pc_reg : 32'h0;
   assign pcback          = pcback_reg;
   assign instructionback = instback_reg;
   assign pc_plus4        = pc_reg + WORD_BYTES;

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      buf_pc4_next  = buf_pc4_reg;
      buf_inst_next = buf_inst_reg;
      pcback_next   = pcback_reg;
      instback_next = instback_reg;
      ImemReq       = 1'b0;

      if (Reset) begin
         if (state_reg == REQ) begin
            ImemReq = 1'b1;
         end else begin
            ImemReq = IFIDWrite & ~PCSrc;
         end
      end

      if (PCSrc) begin
         // Redirect flushes everything and drops any response arriving this cycle.
         pc_next       = {BranchTarget[31:2], 2'b00};
         buf_pc4_next  = 32'h0;
         buf_inst_next = NOP_INSTR;
         state_next    = REQ;
         pcback_next   = 32'h0;
         instback_next = NOP_INSTR;
      end else begin
         if (IFIDWrite) begin
            pcback_next   = PCAddResult;
            instback_next = Instruction;
         end
         if (ImemReq && ImemReady) begin
            buf_inst_next = ImemRdata;
            buf_pc4_next  = pc_plus4;
            pc_next       = pc_plus4;
            state_next    = FULL;
         end else if (state_reg == FULL && IFIDWrite) begin
            state_next = REQ;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_reg    <= REQ;
         pc_reg       <= RESET_PC;
         buf_pc4_reg  <= 32'h0;
         buf_inst_reg <= NOP_INSTR;
         pcback_reg   <= 32'h0;
         instback_reg <= NOP_INSTR;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         buf_pc4_reg  <= buf_pc4_next;
         buf_inst_reg <= buf_inst_next;
         pcback_reg   <= pcback_next;
         instback_reg <= instback_next;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a slot-level fetch model pushes expected
// responses; two monitors pop and compare the handshake and the presented/mirror outputs.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        IFIDWrite = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic        ImemReady = 1'b0;
   logic [31:0] ImemRdata;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic [31:0] PCAddResult;
   logic [31:0] Instruction;
   logic        FetchValid;
   logic [31:0] pcback;
   logic [31:0] instructionback;

   instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .IFIDWrite(IFIDWrite),
      .PCSrc(PCSrc),
      .BranchTarget(BranchTarget),
      .ImemReq(ImemReq),
      .ImemAddr(ImemAddr),
      .ImemReady(ImemReady),
      .ImemRdata(ImemRdata),
      .PCAddResult(PCAddResult),
      .Instruction(Instruction),
      .FetchValid(FetchValid),
      .pcback(pcback),
      .instructionback(instructionback)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   assign ImemRdata = mem_word(ImemAddr);

   typedef struct {
      logic        v;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic [31:0] pcb;
      logic [31:0] ib;
   } out_t;

   typedef struct {
      logic        req;
      logic [31:0] addr;
   } req_t;

   out_t q_out[$];
   req_t q_req[$];

   // Model: the next word to fetch plus the one slot offered to IF/ID.
   logic [31:0] m_addr = 32'h0;
   logic        m_v = 1'b0;
   logic [31:0] m_pc4 = 32'h0;
   logic [31:0] m_inst = 32'h0;
   logic [31:0] m_pcb = 32'h0;
   logic [31:0] m_ib = 32'h0;
   logic        m_init = 1'b0;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic s,
                        input logic [31:0] t, input logic rdy);
      out_t o;
      req_t q;
      logic requesting;
      @(negedge Clk);
      Reset = r;
      IFIDWrite = w;
      PCSrc = s;
      BranchTarget = t;
      ImemReady = rdy;
      if (m_init) begin
         q.req  = r && (!m_v || (w && !s));
         q.addr = r ? m_addr : 32'h0;
         q_req.push_back(q);
      end
      if (!r) begin
         m_addr = RST_PC;
         m_v = 1'b0; m_pc4 = 32'h0; m_inst = 32'h0;
         m_pcb = 32'h0; m_ib = 32'h0;
         m_init = 1'b1;
      end else if (s) begin
         m_addr = {t[31:2], 2'b00};
         m_v = 1'b0; m_pc4 = 32'h0; m_inst = 32'h0;
         m_pcb = 32'h0; m_ib = 32'h0;
      end else begin
         requesting = !m_v || w;
         if (w) begin
            m_pcb = m_v ? m_pc4 : 32'h0;
            m_ib  = m_v ? m_inst : 32'h0;
         end
         if (requesting) begin
            if (rdy) begin
               m_v = 1'b1;
               m_pc4 = m_addr + 32'd4;
               m_inst = mem_word(m_addr);
               m_addr = m_addr + 32'd4;
            end else begin
               m_v = 1'b0;
            end
         end
      end
      o.v = m_v;
      o.pc4 = m_v ? m_pc4 : 32'h0;
      o.inst = m_v ? m_inst : 32'h0;
      o.pcb = m_pcb;
      o.ib = m_ib;
      q_out.push_back(o);
   endtask

   // Registered outputs, one step after the edge.
   initial begin
      out_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (q_out.size() != 0) begin
            e = q_out.pop_front();
            chk("FetchValid", {31'h0, FetchValid}, {31'h0, e.v});
            chk("PCAddResult", PCAddResult, e.pc4);
            chk("Instruction", Instruction, e.inst);
            chk("pcback", pcback, e.pcb);
            chk("instructionback", instructionback, e.ib);
         end
      end
   end

   // Combinational request side, after inputs settle mid-cycle.
   initial begin
      req_t e;
      forever begin
         @(negedge Clk);
         #3;
         if (q_req.size() != 0) begin
            e = q_req.pop_front();
            chk("ImemReq", {31'h0, ImemReq}, {31'h0, e.req});
            chk("ImemAddr", ImemAddr, e.addr);
         end
      end
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      // Straight-line fetch from reset
      repeat (3) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      // Memory wait: bubbles reach the mirror
      repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      // Stall holds everything
      repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      // Redirect with a coincident response, then target fetch
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b1);
      repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      // PC wrap-around
      drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      // Reset while waiting in REQ
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      // Random traffic
      for (int i = 0; i < 500; i++) begin
         drive(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
               $urandom, ($urandom % 3) != 0);
      end
      repeat (3) @(negedge Clk);
      chk("out_queue_drained", q_out.size(), 32'd0);
      chk("req_queue_drained", q_req.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
